// File: rtl/const_regfile_stream.sv
// Constant register file with direct writes, a burst stream loader and registered multi-port sub-word reads.
// Build option: define CRF_BYPASS_EN to forward same-cycle write data to reads of the register being written.
module const_regfile_stream #(
   parameter  int NUM_REGS     = 16,
   parameter  int WORD_W       = 64,
   parameter  int READ_DWIDTH  = 32,
   parameter  int NUM_RD_PORTS = 2,
   localparam int SUBS         = WORD_W / READ_DWIDTH,
   localparam int WA           = $clog2(NUM_REGS),
   localparam int RA           = $clog2(NUM_REGS * SUBS)
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic                                Write_En,
   input  logic [WA-1:0]                       Write_Addr,
   input  logic [WORD_W-1:0]                   In_Const,
   input  logic                                Load_Start,
   input  logic [WA-1:0]                       Load_Base,
   input  logic [WA:0]                         Load_Count,
   input  logic                                In_Valid,
   output logic                                In_Ready,
   output logic                                Load_Busy,
   output logic                                Load_Done,
   input  logic [NUM_RD_PORTS-1:0]             Read_En,
   input  logic [NUM_RD_PORTS*RA-1:0]          Read_Addr,
   output logic [NUM_RD_PORTS*READ_DWIDTH-1:0] Read_Data,
   output logic [NUM_RD_PORTS-1:0]             Read_Valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WA-1:0]     ptr_q, ptr_d;
   logic [WA:0]       cnt_q, cnt_d;
   logic [WA:0]       count_clamped;
   logic [WORD_W-1:0] regs_q [NUM_REGS];

   logic              wr_en;
   logic [WA-1:0]     wr_addr;
   logic [WORD_W-1:0] wr_data;

   assign count_clamped = (Load_Count > (WA+1)'(NUM_REGS)) ? (WA+1)'(NUM_REGS) : Load_Count;

   // Direct and stream writes are exclusive by state, so one write port suffices.
   assign wr_en   = ((state_q == IDLE) && Write_En) || ((state_q == LOAD) && In_Valid);
   assign wr_addr = (state_q == LOAD) ? ptr_q : Write_Addr;
   assign wr_data = In_Const;

   assign In_Ready  = (state_q == LOAD);
   assign Load_Busy = (state_q == LOAD);
   assign Load_Done = (state_q == DONE);

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (Load_Start) begin
               ptr_d   = Load_Base;
               cnt_d   = count_clamped;
               state_d = (count_clamped == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (In_Valid) begin
               ptr_d = ptr_q + 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == (WA+1)'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the storage array is reset explicitly because a reset must wipe any partially loaded burst.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [RA-1:0]          addr;
      int unsigned            reg_idx;
      int unsigned            sub_idx;
      logic [WORD_W-1:0]      word;
      logic [READ_DWIDTH-1:0] rd_data_d, rd_data_q;
      logic                   rd_valid_q;

      assign addr = Read_Addr[p*RA +: RA];

      always_comb begin
         reg_idx = 32'(addr) / SUBS;
         sub_idx = 32'(addr) % SUBS;
         word    = '0;
         if (reg_idx < NUM_REGS) word = regs_q[reg_idx[WA-1:0]];
`ifdef CRF_BYPASS_EN
         if (wr_en && (32'(wr_addr) == reg_idx)) word = wr_data;
`endif
         rd_data_d = '0;
         // Sub-word 0 is the most significant slice of the word.
         if (Read_En[p]) rd_data_d = READ_DWIDTH'(word >> ((SUBS - 1 - sub_idx) * READ_DWIDTH));
      end

      always_ff @(posedge Clk) begin
         if (Reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= Read_En[p];
         end
      end

      assign Read_Data[p*READ_DWIDTH +: READ_DWIDTH] = rd_data_q;
      assign Read_Valid[p]                           = rd_valid_q;
   end

endmodule
